instr_sequencer: RTL and testbench

// Control-step sequencer for the 8-register datapath. Captures a 9-bit instruction
// (III XXX YYY) on a run request and steps it through T1..T3. Each step drives the

---
 rtl/instr_sequencer.sv | 95 +++++++++
 tb/tb_instr_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: captures a 9-bit instruction on run and steps T1..T3 driving datapath controls.
module instr_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [8:0]       instr,
   output logic [2:0]       XXX,
   output logic [2:0]       YYY,
   output logic             fn_sig,
   output logic             sn_sig,
   output logic             reg_wr,
   output logic             din_out,
   output logic             a_load,
   output logic             g_load,
   output logic             g_out,
   output logic [1:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);
   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
   state_t state, nxt;
   logic [8:0] ir;
   logic [2:0] op;
   assign op  = ir[8:6];
   assign XXX = ir[5:3];
   assign YYY = ir[2:0];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ir        <= '0;
         instr_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && run) ir <= instr;
         if (done) instr_cnt <= instr_cnt + 1'b1;
      end
   end
   always_comb begin
      nxt     = IDLE;
      fn_sig  = 1'b0;
      sn_sig  = 1'b0;
      reg_wr  = 1'b0;
      din_out = 1'b0;
      a_load  = 1'b0;
      g_load  = 1'b0;
      g_out   = 1'b0;
      alu_op  = 2'b00;
      busy    = state != IDLE;
      done    = 1'b0;
      illegal = 1'b0;
      case (state)
         IDLE: nxt = run ? T1 : IDLE;
         T1: begin
            if (op[2]) begin
               done    = 1'b1;
               illegal = 1'b1;
            end else if (op[1]) begin
               sn_sig = 1'b1;
               a_load = 1'b1;
               nxt    = T2;
            end else begin
               fn_sig  = ~op[0];
               din_out = op[0];
               g_load  = 1'b1;
               nxt     = T2;
            end
         end
         T2: begin
            // ADD/SUB compute here; MV/MVI already finish with the write-back
            if (op[1]) begin
               fn_sig = 1'b1;
               g_load = 1'b1;
               alu_op = op[0] ? 2'b10 : 2'b01;
               nxt    = T3;
            end else begin
               g_out  = 1'b1;
               sn_sig = 1'b1;
               reg_wr = 1'b1;
               done   = 1'b1;
            end
         end
         T3: begin
            g_out  = 1'b1;
            sn_sig = 1'b1;
            reg_wr = 1'b1;
            done   = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; expected per-cycle control vectors queued at issue, checked on negedge.
module tb_instr_sequencer;
   logic       clk = 1'b0;
   logic       rst_n, run;
   logic [8:0] instr;
   logic [2:0] XXX, YYY;
   logic       fn_sig, sn_sig, reg_wr, din_out, a_load, g_load, g_out, busy, done, illegal;
   logic [1:0] alu_op;
   logic [7:0] instr_cnt;
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] cnt_m = 8'd0;
   logic [17:0] q[$];
   logic [17:0] exp_v, got_v;
   // control field order: fn sn wr din a_ld g_ld g_out | alu | busy done illegal
   localparam logic [11:0] C_IDLE = 12'b0000000_00_000;
   localparam logic [11:0] C_MV1  = 12'b1000010_00_100;
   localparam logic [11:0] C_MVI1 = 12'b0001010_00_100;
   localparam logic [11:0] C_ADD1 = 12'b0100100_00_100;
   localparam logic [11:0] C_ADD2 = 12'b1000010_01_100;
   localparam logic [11:0] C_SUB2 = 12'b1000010_10_100;
   localparam logic [11:0] C_WB   = 12'b0110001_00_110;
   localparam logic [11:0] C_ILL  = 12'b0000000_00_111;
   instr_sequencer #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .XXX(XXX), .YYY(YYY),
      .fn_sig(fn_sig), .sn_sig(sn_sig), .reg_wr(reg_wr), .din_out(din_out),
      .a_load(a_load), .g_load(g_load), .g_out(g_out), .alu_op(alu_op),
      .busy(busy), .done(done), .illegal(illegal), .instr_cnt(instr_cnt)
   );
   always #5 clk = ~clk;
   assign got_v = {XXX, YYY, fn_sig, sn_sig, reg_wr, din_out, a_load, g_load, g_out, alu_op, busy, done, illegal};
   task automatic push_idle(input logic [8:0] ins);
      q.push_back({ins[5:0], C_IDLE});
   endtask
   task automatic push_seq(input logic [8:0] ins);
      case (ins[8:6])
         3'b000: begin q.push_back({ins[5:0], C_MV1});  q.push_back({ins[5:0], C_WB}); end
         3'b001: begin q.push_back({ins[5:0], C_MVI1}); q.push_back({ins[5:0], C_WB}); end
         3'b010: begin q.push_back({ins[5:0], C_ADD1}); q.push_back({ins[5:0], C_ADD2}); q.push_back({ins[5:0], C_WB}); end
         3'b011: begin q.push_back({ins[5:0], C_ADD1}); q.push_back({ins[5:0], C_SUB2}); q.push_back({ins[5:0], C_WB}); end
         default: q.push_back({ins[5:0], C_ILL});
      endcase
   endtask
   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1; instr = 9'b010_111_111;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (got_v !== 18'd0) begin n_err++; $display("FAIL reset_outputs: got %h want %h", got_v, 18'd0); end
      n_cmp++;
      if (instr_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", instr_cnt); end
      run = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (got_v !== 18'd0) begin n_err++; $display("FAIL reset_release_idle: got %h want %h", got_v, 18'd0); end
   endtask
   task automatic test_single(input logic [8:0] ins, input string tag);
      int i = 0;
      run = 1'b1; instr = ins;
      push_seq(ins);
      @(negedge clk);
      run = 1'b0; instr = 9'b111_111_111;
      push_idle(ins);
      while (q.size() > 0) begin
         exp_v = q.pop_front();
         n_cmp++;
         if (got_v !== exp_v) begin n_err++; $display("FAIL %s_step%0d: got %h want %h", tag, i, got_v, exp_v); end
         n_cmp++;
         if (instr_cnt !== cnt_m) begin n_err++; $display("FAIL %s_cnt%0d: got %0d want %0d", tag, i, instr_cnt, cnt_m); end
         if (exp_v[1]) cnt_m++;
         i++;
         if (q.size() > 0) @(negedge clk);
      end
   endtask
   task automatic test_back_to_back();
      int i = 0;
      run = 1'b1; instr = 9'b001_111_000;
      push_seq(9'b001_111_000);
      push_idle(9'b001_111_000);
      push_seq(9'b000_011_110);
      push_idle(9'b000_011_110);
      @(negedge clk);
      instr = 9'b000_011_110;
      while (q.size() > 0) begin
         exp_v = q.pop_front();
         n_cmp++;
         if (got_v !== exp_v) begin n_err++; $display("FAIL b2b_step%0d: got %h want %h", i, got_v, exp_v); end
         n_cmp++;
         if (instr_cnt !== cnt_m) begin n_err++; $display("FAIL b2b_cnt%0d: got %0d want %0d", i, instr_cnt, cnt_m); end
         if (exp_v[1]) cnt_m++;
         if (i == 3) run = 1'b0;
         i++;
         if (q.size() > 0) @(negedge clk);
      end
   endtask
   task automatic test_illegal_wrap();
      int i = 0;
      int n = 256 - int'(cnt_m);
      run = 1'b1; instr = 9'b110_101_010;
      for (int k = 0; k < n; k++) begin
         push_seq(9'b110_101_010);
         push_idle(9'b110_101_010);
      end
      @(negedge clk);
      while (q.size() > 0) begin
         exp_v = q.pop_front();
         n_cmp++;
         if (got_v !== exp_v) begin n_err++; $display("FAIL illegal_step%0d: got %h want %h", i, got_v, exp_v); end
         n_cmp++;
         if (instr_cnt !== cnt_m) begin n_err++; $display("FAIL illegal_cnt%0d: got %0d want %0d", i, instr_cnt, cnt_m); end
         if (exp_v[1]) cnt_m++;
         i++;
         if (q.size() == 0) run = 1'b0;
         else @(negedge clk);
      end
      n_cmp++;
      if (instr_cnt !== 8'd0) begin n_err++; $display("FAIL cnt_wrap: got %0d want 0", instr_cnt); end
   endtask
   task automatic test_reset_mid();
      run = 1'b1; instr = 9'b010_100_001;
      push_seq(9'b010_100_001);
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_v = q.pop_front();
         n_cmp++;
         if (got_v !== exp_v) begin n_err++; $display("FAIL midrst_step%0d: got %h want %h", i, got_v, exp_v); end
         if (i == 0) @(negedge clk);
      end
      q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      cnt_m = 8'd0;
      n_cmp++;
      if (got_v !== 18'd0) begin n_err++; $display("FAIL midrst_abort: got %h want %h", got_v, 18'd0); end
      n_cmp++;
      if (instr_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", instr_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (got_v !== 18'd0) begin n_err++; $display("FAIL midrst_no_done: got %h want %h", got_v, 18'd0); end
   endtask
   initial begin
      test_reset();
      test_single(9'b000_010_101, "mv");
      @(negedge clk);
      test_single(9'b010_001_011, "add");
      @(negedge clk);
      test_single(9'b011_110_100, "sub");
      @(negedge clk);
      test_back_to_back();
      @(negedge clk);
      test_single(9'b110_101_010, "illegal");
      @(negedge clk);
      test_illegal_wrap();
      @(negedge clk);
      test_reset_mid();
      test_single(9'b001_000_111, "recover");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
